rt_head_proc: RTL

Clocked head-flit route processor for the synchronous wrapper of the SDM router input port. It accepts flits on a valid/ready link, decodes the 1-of-4 hop-count digits carried in each head flit, and selects an XY output port. On the chosen dimension it decrements the digit, using the same digit encoding as the asynchronous hop-count decrementer. It locks that port until the packet's tail and emits the rewritten flit through a one-stage output register to the switch allocator.

---
 rtl/rt_pkg.sv | 25 ++
 rtl/digit_dec.sv | 24 ++
 rtl/rt_head_proc.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rt_pkg.sv
// Shared definitions for the head-flit route processor.
// - Port one-hot codes, ordered {W,S,E,N,L} = bits [4:0].
// - Bit offsets of the route field carried in head flits.
// - FSM state encoding.
package rt_pkg;

    localparam logic [4:0] P_L = 5'b00001;
    localparam logic [4:0] P_N = 5'b00010;
    localparam logic [4:0] P_E = 5'b00100;
    localparam logic [4:0] P_S = 5'b01000;
    localparam logic [4:0] P_W = 5'b10000;

    // Route field layout: {ydir, y[3:0], xdir, x[3:0]}
    localparam int X_LSB = 0;
    localparam int X_DIR = 4;
    localparam int Y_LSB = 5;
    localparam int Y_DIR = 9;
    localparam int RF_W  = 10;

    typedef enum logic {
        WAIT_HEAD = 1'b0,
        IN_PKT    = 1'b1
    } rt_state_e;

endpackage

// File: rtl/digit_dec.sv
// One-hot hop-count digit decoder/decrementer.
// Ports:
//   d     in  4  one-hot digit, value = index of the set bit
//   d_o   out 4  digit decremented by one hop (shift toward bit 0)
//   zero  out 1  digit is 4'b0001 (no hops left)
//   nzero out 1  valid digit with hops left
//   bad   out 1  digit does not have exactly one bit set
module digit_dec (
    input  logic [3:0] d,
    output logic [3:0] d_o,
    output logic       zero,
    output logic       nzero,
    output logic       bad
);

    always_comb begin
        d_o   = {1'b0, d[3:1]};
        zero  = (d == 4'b0001);
        bad   = !((d == 4'b0001) || (d == 4'b0010) ||
                  (d == 4'b0100) || (d == 4'b1000));
        nzero = !zero && !bad;
    end

endmodule

// File: rtl/rt_head_proc.sv
// Head-flit route processor: decodes the XY hop-count digits of a head
// flit, picks the output port, decrements the digit of the dimension
// being travelled, locks that port until the packet tail, and registers
// the flit for the switch allocator.
// Handshake: a transfer happens on a link in any cycle where valid and
// ready are both high at the rising edge; a valid flit is held stable
// until it is taken, and in_rdy = !out_vld | out_rdy.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_vld/in_rdy      input link handshake
//   in_data/head/tail  input flit, route field in bits [9:0]
//   out_vld/out_rdy    output register handshake
//   out_data/head/tail registered (possibly rewritten) flit
//   out_port           one-hot output port {W,S,E,N,L}
//   err                one-cycle protocol/encoding error pulse
//   dbg_state          current FSM state
module rt_head_proc
    import rt_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [DW-1:0] in_data,
    input  logic          in_head,
    input  logic          in_tail,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_data,
    output logic          out_head,
    output logic          out_tail,
    output logic [4:0]    out_port,
    output logic          err,
    output rt_state_e     dbg_state
);

    rt_state_e state, state_nxt;
    logic [4:0] lock_port, lock_nxt;

    logic [3:0] x_dig, y_dig, x_dec, y_dec;
    logic       x_zero, x_nz, x_bad;
    logic       y_zero, y_nz, y_bad;

    logic [RF_W-1:0] route_field;
    logic [4:0]      route_port;
    logic            route_bad;

    logic          accept;
    logic          load;
    logic [DW-1:0] ld_data;
    logic          ld_head, ld_tail;
    logic [4:0]    ld_port;
    logic          err_nxt;

    assign x_dig     = in_data[X_LSB +: 4];
    assign y_dig     = in_data[Y_LSB +: 4];
    assign in_rdy    = !out_vld || out_rdy;
    assign accept    = in_vld && in_rdy;
    assign dbg_state = state;

    digit_dec u_x_dec (
        .d     (x_dig),
        .d_o   (x_dec),
        .zero  (x_zero),
        .nzero (x_nz),
        .bad   (x_bad)
    );

    digit_dec u_y_dec (
        .d     (y_dig),
        .d_o   (y_dec),
        .zero  (y_zero),
        .nzero (y_nz),
        .bad   (y_bad)
    );

    // XY routing: finish the X dimension before starting Y. A malformed
    // digit sends the flit to the local port untouched so it can be
    // inspected rather than misrouted.
    always_comb begin
        route_field = in_data[RF_W-1:0];
        route_port  = P_L;
        route_bad   = x_bad || y_bad;
        if (!route_bad) begin
            if (x_nz) begin
                route_port              = in_data[X_DIR] ? P_W : P_E;
                route_field[X_LSB +: 4] = x_dec;
            end else if (y_nz) begin
                route_port              = in_data[Y_DIR] ? P_S : P_N;
                route_field[Y_LSB +: 4] = y_dec;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        lock_nxt  = lock_port;
        load      = 1'b0;
        ld_data   = in_data;
        ld_head   = 1'b0;
        ld_tail   = in_tail;
        ld_port   = lock_port;
        err_nxt   = 1'b0;
        unique case (state)
            WAIT_HEAD: begin
                if (accept) begin
                    if (in_head) begin
                        load      = 1'b1;
                        ld_data   = {in_data[DW-1:RF_W], route_field};
                        ld_head   = 1'b1;
                        ld_port   = route_port;
                        lock_nxt  = route_port;
                        err_nxt   = route_bad;
                        state_nxt = in_tail ? WAIT_HEAD : IN_PKT;
                    end else begin
                        // Orphan body/tail flit: consumed and dropped.
                        err_nxt = 1'b1;
                    end
                end
            end
            IN_PKT: begin
                if (accept) begin
                    // A stray head inside a packet is demoted to a body flit.
                    load    = 1'b1;
                    err_nxt = in_head;
                    if (in_tail) state_nxt = WAIT_HEAD;
                end
            end
            default: state_nxt = WAIT_HEAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_HEAD;
            lock_port <= '0;
            out_vld   <= 1'b0;
            out_data  <= '0;
            out_head  <= 1'b0;
            out_tail  <= 1'b0;
            out_port  <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            lock_port <= lock_nxt;
            err       <= err_nxt;
            // load implies in_rdy, so a stalled flit is never overwritten.
            if (load) begin
                out_vld  <= 1'b1;
                out_data <= ld_data;
                out_head <= ld_head;
                out_tail <= ld_tail;
                out_port <= ld_port;
            end else if (out_rdy) begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule
